prescaled_updown_counter: RTL and testbench

- Parametrised successor of the team's fixed 4-bit prescaled up counter.
- A programmable prescaler divides clk into a step strobe.
- A modulo-(MAX_VAL+1) counter advances on each strobe, with run-time direction, wrap/saturate mode, enable, synchronous load and a terminal-count flag.
- Used for display/timebase counting: seconds, BCD digits, LED sequencers.

---
 rtl/prescaled_updown_counter_pkg.sv | 20 ++
 rtl/prescaled_updown_counter_if.sv | 25 ++
 rtl/prescaled_updown_counter_prescaler.sv | 49 ++++
 rtl/prescaled_updown_counter.sv | 90 +++++++++
 tb/tb_prescaled_updown_counter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/prescaled_updown_counter_pkg.sv
// Shared constants and helpers for the prescaled up/down counter family.
package pkg_counter;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Limit a value to the counter's terminal value.
    function automatic logic [31:0] clamp_cnt(input logic [31:0] value, input logic [31:0] max);
        logic [31:0] res;
        if (value > max) begin
            res = max;
        end else begin
            res = value;
        end
        return res;
    endfunction

endpackage

// File: rtl/prescaled_updown_counter_if.sv
// Control/status bundle of the prescaled up/down counter.
interface prescaled_updown_counter_if #(
    parameter int CNT_W = 4,
    parameter int DIV_W = 27
);
    logic             en;
    logic             dir;
    logic             sat;
    logic [DIV_W-1:0] div;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] cout;
    logic             tick;
    logic             tc;

    modport master (
        output en, dir, sat, div, load, load_val,
        input  cout, tick, tc
    );

    modport slave (
        input  en, dir, sat, div, load, load_val,
        output cout, tick, tc
    );
endinterface

// File: rtl/prescaled_updown_counter_prescaler.sv
// Programmable clock divider producing a combinational step enable every div+1 enabled cycles.
module clk_prescaler #(
    parameter int DIV_W = 27
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             step
);

    logic [DIV_W-1:0] psc_r;
    logic             hit_s;

    // Using >= lets a div decrease below psc fire on the next edge instead of waiting a full wrap.
    always_comb begin
        hit_s = 1'b0;
        step  = 1'b0;
        if (psc_r >= div) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
        if (en && !clear) begin
            step = hit_s;
        end else begin
            step = 1'b0;
        end
    end

    // Prescale count register; a load clears it so the period restarts.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            psc_r <= '0;
        end else if (clear) begin
            psc_r <= '0;
        end else if (en) begin
            if (hit_s) begin
                psc_r <= '0;
            end else begin
                psc_r <= psc_r + DIV_W'(1);
            end
        end else begin
            psc_r <= psc_r;
        end
    end

endmodule

// File: rtl/prescaled_updown_counter.sv
// Modulo-(MAX_VAL+1) up/down counter advanced by a programmable prescaler, with load and terminal-count strobe.
module prescaled_updown_counter
    import pkg_counter::*;
#(
    parameter int CNT_W   = 4,
    parameter int MAX_VAL = 2**CNT_W-1,
    parameter int DIV_W   = 27
) (
    input logic                       clk,
    input logic                       clr,
    prescaled_updown_counter_if.slave bus
);

    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_VAL);
    localparam logic [CNT_W-1:0] ZERO_C = CNT_W'(0);

    logic             step_s;
    logic [CNT_W-1:0] cnt_eff_s;
    logic [CNT_W-1:0] load_clamp_s;
    logic [CNT_W-1:0] cout_nxt_s;
    logic             tick_nxt_s;
    logic             tc_nxt_s;
    logic [CNT_W-1:0] cout_r;
    logic             tick_r;
    logic             tc_r;

    clk_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk   (clk),
        .clr   (clr),
        .en    (bus.en),
        .clear (bus.load),
        .div   (bus.div),
        .step  (step_s)
    );

    // Next counter value and strobes; an out-of-range count is treated as the terminal value.
    always_comb begin
        cnt_eff_s    = CNT_W'(clamp_cnt(32'(cout_r), 32'(MAX_VAL)));
        load_clamp_s = CNT_W'(clamp_cnt(32'(bus.load_val), 32'(MAX_VAL)));
        cout_nxt_s   = cout_r;
        tick_nxt_s   = 1'b0;
        tc_nxt_s     = 1'b0;
        if (bus.load) begin
            cout_nxt_s = load_clamp_s;
        end else if (step_s) begin
            tick_nxt_s = 1'b1;
            case (bus.dir)
                DIR_UP: begin
                    if (cnt_eff_s == MAX_C) begin
                        tc_nxt_s   = 1'b1;
                        cout_nxt_s = (bus.sat == MODE_SAT) ? MAX_C : ZERO_C;
                    end else begin
                        cout_nxt_s = cnt_eff_s + CNT_W'(1);
                    end
                end
                DIR_DOWN: begin
                    if (cnt_eff_s == ZERO_C) begin
                        tc_nxt_s   = 1'b1;
                        cout_nxt_s = (bus.sat == MODE_SAT) ? ZERO_C : MAX_C;
                    end else begin
                        cout_nxt_s = cnt_eff_s - CNT_W'(1);
                    end
                end
                default: begin
                    cout_nxt_s = cnt_eff_s;
                end
            endcase
        end else begin
            cout_nxt_s = cout_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cout_r <= '0;
            tick_r <= 1'b0;
            tc_r   <= 1'b0;
        end else begin
            cout_r <= cout_nxt_s;
            tick_r <= tick_nxt_s;
            tc_r   <= tc_nxt_s;
        end
    end

    assign bus.cout = cout_r;
    assign bus.tick = tick_r;
    assign bus.tc   = tc_r;

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Randomised scoreboard bench: a MAX_VAL=15 and a MAX_VAL=9 counter driven alike, each against an arithmetic model.
module tb_prescaled_updown_counter;

    logic clk;
    logic clr;
    int   checks;
    int   errors;

    int   exp_q0[$];
    int   exp_q1[$];
    int   m_psc[2];
    int   m_cnt[2];
    int   m_max[2];

    prescaled_updown_counter_if #(.CNT_W(4), .DIV_W(27)) if16 ();
    prescaled_updown_counter_if #(.CNT_W(4), .DIV_W(27)) if9 ();

    prescaled_updown_counter #(.CNT_W(4), .MAX_VAL(15), .DIV_W(27)) dut16 (
        .clk (clk),
        .clr (clr),
        .bus (if16)
    );

    prescaled_updown_counter #(.CNT_W(4), .MAX_VAL(9), .DIV_W(27)) dut9 (
        .clk (clk),
        .clr (clr),
        .bus (if9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit en, input bit dir, input bit sat, input int div,
                         input bit load, input int lv);
        if16.en = en;  if16.dir = dir;  if16.sat = sat;  if16.div = 27'(div);
        if16.load = load;  if16.load_val = 4'(lv);
        if9.en = en;   if9.dir = dir;   if9.sat = sat;   if9.div = 27'(div);
        if9.load = load;   if9.load_val = 4'(lv);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_psc[i] = 0;
            m_cnt[i] = 0;
        end
    endtask

    // One rising edge: advance both models from the applied inputs and queue the expected outputs.
    task automatic edge_step();
        int  en, dir, sat, div, load, lv;
        bit  tk, t;
        @(posedge clk);
        en = int'(if16.en); dir = int'(if16.dir); sat = int'(if16.sat);
        div = int'(if16.div); load = int'(if16.load); lv = int'(if16.load_val);
        for (int i = 0; i < 2; i++) begin
            tk = 1'b0;
            t  = 1'b0;
            if (load != 0) begin
                m_cnt[i] = (lv < m_max[i]) ? lv : m_max[i];
                m_psc[i] = 0;
            end else if (en != 0) begin
                if (m_psc[i] >= div) begin
                    m_psc[i] = 0;
                    tk = 1'b1;
                    if (dir != 0) begin
                        t = (m_cnt[i] == m_max[i]);
                        if (sat != 0) m_cnt[i] = (m_cnt[i] + 1 > m_max[i]) ? m_max[i] : m_cnt[i] + 1;
                        else          m_cnt[i] = (m_cnt[i] + 1) % (m_max[i] + 1);
                    end else begin
                        t = (m_cnt[i] == 0);
                        if (sat != 0) m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
                        else          m_cnt[i] = (m_cnt[i] + m_max[i]) % (m_max[i] + 1);
                    end
                end else begin
                    m_psc[i] = m_psc[i] + 1;
                end
            end
            if (i == 0) exp_q0.push_back(m_cnt[i] * 4 + int'(tk) * 2 + int'(t));
            else        exp_q1.push_back(m_cnt[i] * 4 + int'(tk) * 2 + int'(t));
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) edge_step();
    endtask

    // Asynchronous clear pulse placed between edges, checked before the next rising edge.
    task automatic clr_pulse();
        #2;
        clr = 1'b1;
        #1;
        check("clr_cout16", int'(if16.cout), 0);
        check("clr_tick16", int'(if16.tick), 0);
        check("clr_tc16",   int'(if16.tc), 0);
        check("clr_cout9",  int'(if9.cout), 0);
        #1;
        clr = 1'b0;
        model_reset();
    endtask

    // Monitor: the counter presents a result every cycle, compare it with the oldest expectation.
    always @(negedge clk) begin
        int e;
        if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            check("sb_dut16", int'(if16.cout) * 4 + int'(if16.tick) * 2 + int'(if16.tc), e);
        end
        if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            check("sb_dut9", int'(if9.cout) * 4 + int'(if9.tick) * 2 + int'(if9.tc), e);
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        m_max[0] = 15;
        m_max[1] = 9;
        model_reset();
        clr = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 10, 1'b0, 0);
        #2;
        check("rst_cout16", int'(if16.cout), 0);
        check("rst_tick16", int'(if16.tick), 0);
        check("rst_tc16",   int'(if16.tc), 0);
        #1;
        clr = 1'b0;

        // Free run up, wrap, div=10.
        run(165);
        check("up_cout16_165", int'(if16.cout), 15);
        check("up_tick16_165", int'(if16.tick), 1);
        check("up_tc16_165",   int'(if16.tc), 0);
        check("up_cout9_165",  int'(if9.cout), 5);
        run(11);
        check("wrap_cout16", int'(if16.cout), 0);
        check("wrap_tc16",   int'(if16.tc), 1);
        check("wrap_tick16", int'(if16.tick), 1);

        // BCD digit at div=0.
        drive(1'b1, 1'b1, 1'b0, 0, 1'b1, 0);
        edge_step();
        drive(1'b1, 1'b1, 1'b0, 0, 1'b0, 0);
        run(9);
        check("bcd_cout9_9", int'(if9.cout), 9);
        check("bcd_tc9_9",   int'(if9.tc), 0);
        edge_step();
        check("bcd_cout9_wrap", int'(if9.cout), 0);
        check("bcd_tc9_wrap",   int'(if9.tc), 1);

        // Saturating down count from 2.
        drive(1'b1, 1'b0, 1'b1, 0, 1'b1, 2);
        edge_step();
        drive(1'b1, 1'b0, 1'b1, 0, 1'b0, 0);
        run(4);
        check("satdn_cout16", int'(if16.cout), 0);
        check("satdn_tc16",   int'(if16.tc), 1);
        check("satdn_cout9",  int'(if9.cout), 0);

        // Load mid-prescale with clamping on the MAX_VAL=9 instance.
        drive(1'b1, 1'b1, 1'b0, 10, 1'b1, 0);
        edge_step();
        drive(1'b1, 1'b1, 1'b0, 10, 1'b0, 0);
        run(6);
        drive(1'b1, 1'b1, 1'b0, 10, 1'b1, 14);
        edge_step();
        check("ld_cout16", int'(if16.cout), 14);
        check("ld_cout9",  int'(if9.cout), 9);
        drive(1'b1, 1'b1, 1'b0, 10, 1'b0, 0);
        run(10);
        check("ld_tick16_10", int'(if16.tick), 0);
        edge_step();
        check("ld_tick16_11", int'(if16.tick), 1);
        check("ld_cout16_11", int'(if16.cout), 15);
        check("ld_tc9_11",    int'(if9.tc), 1);

        // Enable hold at psc=4.
        drive(1'b1, 1'b1, 1'b0, 10, 1'b1, 0);
        edge_step();
        drive(1'b1, 1'b1, 1'b0, 10, 1'b0, 0);
        run(4);
        drive(1'b0, 1'b1, 1'b0, 10, 1'b0, 0);
        run(5);
        check("hold_cout16", int'(if16.cout), 0);
        check("hold_tick16", int'(if16.tick), 0);
        drive(1'b1, 1'b1, 1'b0, 10, 1'b0, 0);
        run(7);
        check("resume_tick16", int'(if16.tick), 1);
        check("resume_cout16", int'(if16.cout), 1);

        // Async clear at cout=7, then a div reduction below psc.
        drive(1'b0, 1'b1, 1'b0, 10, 1'b1, 7);
        edge_step();
        drive(1'b1, 1'b1, 1'b0, 10, 1'b0, 0);
        run(3);
        check("pre_clr_cout16", int'(if16.cout), 7);
        clr_pulse();
        run(5);
        drive(1'b1, 1'b1, 1'b0, 2, 1'b0, 0);
        edge_step();
        check("divdrop_tick16", int'(if16.tick), 1);
        check("divdrop_cout16", int'(if16.cout), 1);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 4)), $urandom_range(0, 19) == 0, int'($urandom_range(0, 15)));
            if ($urandom_range(0, 199) == 0) clr_pulse();
            edge_step();
        end

        #1;
        check("drain_q0", exp_q0.size(), 0);
        check("drain_q1", exp_q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
